// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - CSR addresses, write masks, field positions and helpers
package csr_pkg;

   localparam logic [13:0] CSR_CRMD   = 14'h0;
   localparam logic [13:0] CSR_PRMD   = 14'h1;
   localparam logic [13:0] CSR_ECFG   = 14'h4;
   localparam logic [13:0] CSR_ESTAT  = 14'h5;
   localparam logic [13:0] CSR_ERA    = 14'h6;
   localparam logic [13:0] CSR_BADV   = 14'h7;
   localparam logic [13:0] CSR_EENTRY = 14'hC;
   localparam logic [13:0] CSR_SAVE0  = 14'h30;
   localparam logic [13:0] CSR_TID    = 14'h40;
   localparam logic [13:0] CSR_TCFG   = 14'h41;
   localparam logic [13:0] CSR_TVAL   = 14'h42;
   localparam logic [13:0] CSR_TICLR  = 14'h44;

   localparam logic [31:0] WMASK_CRMD   = 32'h0000_01FF;
   localparam logic [31:0] WMASK_PRMD   = 32'h0000_0007;
   localparam logic [31:0] WMASK_ECFG   = 32'h0000_1BFF;
   localparam logic [31:0] WMASK_EENTRY = 32'hFFFF_FFC0;
   localparam logic [31:0] WMASK_ALL    = 32'hFFFF_FFFF;

   localparam logic [31:0] CRMD_RESET = 32'h0000_0008;

   localparam int CRMD_IE_BIT       = 2;
   localparam int TCFG_EN_BIT       = 0;
   localparam int TCFG_PERIODIC_BIT = 1;

   typedef enum logic [5:0] {
      ECODE_INT  = 6'h00,
      ECODE_ADEF = 6'h08,
      ECODE_ALE  = 6'h09,
      ECODE_SYS  = 6'h0B,
      ECODE_BRK  = 6'h0C,
      ECODE_INE  = 6'h0D
   } ecode_e;

   function automatic logic [31:0] masked_write(input logic [31:0] old_val,
                                                input logic [31:0] we,
                                                input logic [31:0] wdata,
                                                input logic [31:0] wmask);
      return (old_val & ~(we & wmask)) | (wdata & we & wmask);
   endfunction

endpackage

// File: rtl/csr_timer.sv
// rtl/csr_timer.sv - TVAL countdown with run flag, periodic reload and expire pulse
module csr_timer (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_load,
   input  logic        i_stop,
   input  logic        i_periodic,
   input  logic [29:0] i_init,
   output logic [31:0] o_tval,
   output logic        o_expire
);

   logic [31:0] r_tval;
   logic        r_run;

   // Expire marks the edge on which TVAL steps 1 -> 0; a same-cycle TCFG write pre-empts it.
   assign o_expire = r_run & ~i_load & ~i_stop & (r_tval == 32'd1);
   assign o_tval   = r_tval;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tval <= 32'd0;
         r_run  <= 1'b0;
      end else if (i_load) begin
         r_tval <= {i_init, 2'b00};
         r_run  <= 1'b1;
      end else if (i_stop) begin
         r_run  <= 1'b0;
      end else if (r_run) begin
         if (r_tval != 32'd0) begin
            r_tval <= r_tval - 32'd1;
         end else if (i_periodic) begin
            r_tval <= {i_init, 2'b00};
         end else begin
            r_run  <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/csr_regfile.sv
// rtl/csr_regfile.sv - architectural CSR state, exception save/restore, timer and read port
module csr_regfile
   import csr_pkg::*;
#(
   parameter logic [31:0] TID_RESET = 32'h0,
   parameter int          N_SAVE    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [13:0] WB_csr_waddr,
   input  logic [31:0] WB_csr_we,
   input  logic [31:0] WB_csr_wdata,
   input  logic        WB_ertn,
   input  logic [6:0]  WB_ecode_in,
   input  logic        WB_ecode_we,
   input  logic [31:0] WB_badv_in,
   input  logic        WB_badv_we,
   input  logic [31:0] WB_era_in,
   input  logic        WB_era_we,
   input  logic        WB_era_en,
   input  logic        WB_eentry_en,
   input  logic        WB_store_state,
   input  logic        WB_restore_state,
   input  logic [7:0]  ext_int,
   input  logic [13:0] csr_raddr,
   output logic [31:0] csr_rdata,
   output logic [31:0] csr_redirect_pc,
   output logic        int_pending,
   output logic [1:0]  crmd_plv,
   output logic        crmd_ie
);

   logic [31:0] r_crmd, r_prmd, r_ecfg, r_era, r_badv, r_eentry, r_tid, r_tcfg;
   logic [31:0] r_save [N_SAVE];
   logic [1:0]  r_is_sw;
   logic [7:0]  r_is_hw;
   logic        r_is_timer;
   logic [5:0]  r_ecode;
   logic        r_esubcode;

   logic [31:0] w_crmd_next, w_prmd_next, w_tcfg_next, w_estat, w_tval;
   logic        w_tcfg_load, w_tcfg_stop, w_ticlr, w_timer_expire;
   logic        w_unused;

   assign w_unused = WB_ertn;

   assign w_tcfg_next = (WB_csr_waddr == CSR_TCFG)
                      ? masked_write(r_tcfg, WB_csr_we, WB_csr_wdata, WMASK_ALL) : r_tcfg;
   assign w_tcfg_load = (WB_csr_waddr == CSR_TCFG) && (|WB_csr_we) &&  w_tcfg_next[TCFG_EN_BIT];
   assign w_tcfg_stop = (WB_csr_waddr == CSR_TCFG) && (|WB_csr_we) && !w_tcfg_next[TCFG_EN_BIT];
   assign w_ticlr     = (WB_csr_waddr == CSR_TICLR) && WB_csr_we[0] && WB_csr_wdata[0];

   // PLV/IE sit in bits [2:0] of both CRMD and PRMD; exception entry beats ertn beats software.
   always_comb begin
      w_crmd_next = (WB_csr_waddr == CSR_CRMD)
                  ? masked_write(r_crmd, WB_csr_we, WB_csr_wdata, WMASK_CRMD) : r_crmd;
      w_prmd_next = (WB_csr_waddr == CSR_PRMD)
                  ? masked_write(r_prmd, WB_csr_we, WB_csr_wdata, WMASK_PRMD) : r_prmd;
      if (WB_store_state) begin
         w_prmd_next[2:0] = r_crmd[2:0];
         w_crmd_next[2:0] = 3'b000;
      end else if (WB_restore_state) begin
         w_crmd_next[2:0] = r_prmd[2:0];
      end
   end

   csr_timer u_timer (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_tcfg_load),
      .i_stop     (w_tcfg_stop),
      .i_periodic (w_tcfg_next[TCFG_PERIODIC_BIT]),
      .i_init     (w_tcfg_next[31:2]),
      .o_tval     (w_tval),
      .o_expire   (w_timer_expire)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_crmd     <= CRMD_RESET;
         r_prmd     <= 32'd0;
         r_ecfg     <= 32'd0;
         r_era      <= 32'd0;
         r_badv     <= 32'd0;
         r_eentry   <= 32'd0;
         r_tid      <= TID_RESET;
         r_tcfg     <= 32'd0;
         r_is_sw    <= 2'd0;
         r_is_hw    <= 8'd0;
         r_is_timer <= 1'b0;
         r_ecode    <= 6'd0;
         r_esubcode <= 1'b0;
         for (int i = 0; i < N_SAVE; i++) r_save[i] <= 32'd0;
      end else begin
         r_crmd  <= w_crmd_next;
         r_prmd  <= w_prmd_next;
         r_tcfg  <= w_tcfg_next;
         r_is_hw <= ext_int;
         if (WB_csr_waddr == CSR_ECFG)
            r_ecfg <= masked_write(r_ecfg, WB_csr_we, WB_csr_wdata, WMASK_ECFG);
         if (WB_csr_waddr == CSR_ESTAT)
            r_is_sw <= (r_is_sw & ~WB_csr_we[1:0]) | (WB_csr_wdata[1:0] & WB_csr_we[1:0]);
         if (WB_csr_waddr == CSR_EENTRY)
            r_eentry <= masked_write(r_eentry, WB_csr_we, WB_csr_wdata, WMASK_EENTRY);
         if (WB_csr_waddr == CSR_TID)
            r_tid <= masked_write(r_tid, WB_csr_we, WB_csr_wdata, WMASK_ALL);
         if (WB_era_we)
            r_era <= WB_era_in;
         else if (WB_csr_waddr == CSR_ERA)
            r_era <= masked_write(r_era, WB_csr_we, WB_csr_wdata, WMASK_ALL);
         if (WB_badv_we)
            r_badv <= WB_badv_in;
         else if (WB_csr_waddr == CSR_BADV)
            r_badv <= masked_write(r_badv, WB_csr_we, WB_csr_wdata, WMASK_ALL);
         if (WB_ecode_we) begin
            r_ecode    <= WB_ecode_in[5:0];
            r_esubcode <= WB_ecode_in[6];
         end
         // A clear colliding with expiry must not lose the interrupt.
         if (w_timer_expire)
            r_is_timer <= 1'b1;
         else if (w_ticlr)
            r_is_timer <= 1'b0;
         for (int i = 0; i < N_SAVE; i++) begin
            if (WB_csr_waddr == CSR_SAVE0 + 14'(i))
               r_save[i] <= masked_write(r_save[i], WB_csr_we, WB_csr_wdata, WMASK_ALL);
         end
      end
   end

   assign w_estat = {1'b0, 8'd0, r_esubcode, r_ecode, 3'd0,
                     1'b0, r_is_timer, 1'b0, r_is_hw, r_is_sw};

   always_comb begin
      csr_rdata = 32'd0;
      case (csr_raddr)
         CSR_CRMD:   csr_rdata = r_crmd;
         CSR_PRMD:   csr_rdata = r_prmd;
         CSR_ECFG:   csr_rdata = r_ecfg;
         CSR_ESTAT:  csr_rdata = w_estat;
         CSR_ERA:    csr_rdata = r_era;
         CSR_BADV:   csr_rdata = r_badv;
         CSR_EENTRY: csr_rdata = r_eentry;
         CSR_TID:    csr_rdata = r_tid;
         CSR_TCFG:   csr_rdata = r_tcfg;
         CSR_TVAL:   csr_rdata = w_tval;
         default:    csr_rdata = 32'd0;
      endcase
      for (int i = 0; i < N_SAVE; i++) begin
         if (csr_raddr == CSR_SAVE0 + 14'(i)) csr_rdata = r_save[i];
      end
   end

   assign csr_redirect_pc = WB_eentry_en ? r_eentry : (WB_era_en ? r_era : 32'd0);
   assign int_pending     = r_crmd[CRMD_IE_BIT] & (|(w_estat[12:0] & r_ecfg[12:0]));
   assign crmd_plv        = r_crmd[1:0];
   assign crmd_ie         = r_crmd[CRMD_IE_BIT];

endmodule

// File: tb/tb_csr_regfile.sv
// tb/tb_csr_regfile.sv - randomized and directed checks of csr_regfile against a field-level model
module tb_csr_regfile;

   localparam logic [31:0] TIDR = 32'hA5A5_0001;

   logic        clk = 1'b0;
   logic        rst;
   logic [13:0] WB_csr_waddr;
   logic [31:0] WB_csr_we, WB_csr_wdata;
   logic        WB_ertn;
   logic [6:0]  WB_ecode_in;
   logic        WB_ecode_we;
   logic [31:0] WB_badv_in;
   logic        WB_badv_we;
   logic [31:0] WB_era_in;
   logic        WB_era_we, WB_era_en, WB_eentry_en, WB_store_state, WB_restore_state;
   logic [7:0]  ext_int;
   logic [13:0] csr_raddr;
   logic [31:0] csr_rdata, csr_redirect_pc;
   logic        int_pending;
   logic [1:0]  crmd_plv;
   logic        crmd_ie;

   csr_regfile #(.TID_RESET(TIDR), .N_SAVE(4)) dut (
      .clk(clk), .rst(rst), .WB_csr_waddr(WB_csr_waddr), .WB_csr_we(WB_csr_we),
      .WB_csr_wdata(WB_csr_wdata), .WB_ertn(WB_ertn), .WB_ecode_in(WB_ecode_in),
      .WB_ecode_we(WB_ecode_we), .WB_badv_in(WB_badv_in), .WB_badv_we(WB_badv_we),
      .WB_era_in(WB_era_in), .WB_era_we(WB_era_we), .WB_era_en(WB_era_en),
      .WB_eentry_en(WB_eentry_en), .WB_store_state(WB_store_state),
      .WB_restore_state(WB_restore_state), .ext_int(ext_int), .csr_raddr(csr_raddr),
      .csr_rdata(csr_rdata), .csr_redirect_pc(csr_redirect_pc), .int_pending(int_pending),
      .crmd_plv(crmd_plv), .crmd_ie(crmd_ie)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en = 1'b0;

   // Architectural state held as plain fields.
   logic [31:0] m_crmd, m_prmd, m_ecfg, m_era, m_badv, m_eentry, m_tid, m_tcfg, m_tval;
   logic [31:0] m_save [4];
   logic [1:0]  m_sw;
   logic [7:0]  m_hw;
   logic        m_ti, m_run;
   logic [6:0]  m_ec;

   logic [31:0] n_crmd, n_prmd, n_ecfg, n_era, n_badv, n_eentry, n_tid, n_tcfg, n_tval;
   logic [31:0] n_save [4];
   logic [1:0]  n_sw;
   logic [7:0]  n_hw;
   logic        n_ti, n_run;
   logic [6:0]  n_ec;

   logic [13:0] addrs [18] = '{14'h0, 14'h1, 14'h4, 14'h5, 14'h6, 14'h7, 14'hC, 14'h30, 14'h31,
                               14'h32, 14'h33, 14'h40, 14'h41, 14'h42, 14'h44, 14'h2, 14'h34, 14'h43};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] upd(input logic [31:0] old_val, input logic [31:0] wmask);
      return (old_val & ~(WB_csr_we & wmask)) | (WB_csr_wdata & WB_csr_we & wmask);
   endfunction

   function automatic logic [31:0] m_estat();
      return {1'b0, 8'd0, m_ec[6], m_ec[5:0], 3'd0, 1'b0, m_ti, 1'b0, m_hw, m_sw};
   endfunction

   function automatic logic [31:0] m_read(input logic [13:0] a);
      case (a)
         14'h0:  return m_crmd;
         14'h1:  return m_prmd;
         14'h4:  return m_ecfg;
         14'h5:  return m_estat();
         14'h6:  return m_era;
         14'h7:  return m_badv;
         14'hC:  return m_eentry;
         14'h30, 14'h31, 14'h32, 14'h33: return m_save[a[1:0]];
         14'h40: return m_tid;
         14'h41: return m_tcfg;
         14'h42: return m_tval;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_next();
      logic [13:0] a;
      logic        expire;
      a = WB_csr_waddr;
      expire = 1'b0;
      if (rst) begin
         n_crmd = 32'h8; n_prmd = 0; n_ecfg = 0; n_era = 0; n_badv = 0; n_eentry = 0;
         n_tid = TIDR; n_tcfg = 0; n_tval = 0; n_run = 0; n_sw = 0; n_hw = 0; n_ti = 0; n_ec = 0;
         for (int i = 0; i < 4; i++) n_save[i] = 0;
      end else begin
         n_crmd = m_crmd; n_prmd = m_prmd; n_ecfg = m_ecfg; n_era = m_era; n_badv = m_badv;
         n_eentry = m_eentry; n_tid = m_tid; n_tcfg = m_tcfg; n_tval = m_tval; n_run = m_run;
         n_sw = m_sw; n_ti = m_ti; n_ec = m_ec; n_hw = ext_int;
         for (int i = 0; i < 4; i++) n_save[i] = m_save[i];
         case (a)
            14'h0:  n_crmd = upd(m_crmd, 32'h1FF);
            14'h1:  n_prmd = upd(m_prmd, 32'h7);
            14'h4:  n_ecfg = upd(m_ecfg, 32'h1BFF);
            14'h5:  n_sw = upd({30'd0, m_sw}, 32'h3) & 2'h3;
            14'h6:  n_era = upd(m_era, 32'hFFFF_FFFF);
            14'h7:  n_badv = upd(m_badv, 32'hFFFF_FFFF);
            14'hC:  n_eentry = upd(m_eentry, 32'hFFFF_FFC0);
            14'h30, 14'h31, 14'h32, 14'h33: n_save[a[1:0]] = upd(m_save[a[1:0]], 32'hFFFF_FFFF);
            14'h40: n_tid = upd(m_tid, 32'hFFFF_FFFF);
            14'h41: n_tcfg = upd(m_tcfg, 32'hFFFF_FFFF);
            default: ;
         endcase
         if (WB_store_state) begin
            n_prmd[1:0] = m_crmd[1:0];
            n_prmd[2]   = m_crmd[2];
            n_crmd[1:0] = 2'd0;
            n_crmd[2]   = 1'b0;
         end else if (WB_restore_state) begin
            n_crmd[1:0] = m_prmd[1:0];
            n_crmd[2]   = m_prmd[2];
         end
         if (WB_ecode_we) n_ec = WB_ecode_in;
         if (WB_era_we)   n_era = WB_era_in;
         if (WB_badv_we)  n_badv = WB_badv_in;
         if (a == 14'h41 && WB_csr_we != 0) begin
            if (n_tcfg[0]) begin
               n_tval = n_tcfg & 32'hFFFF_FFFC;
               n_run  = 1'b1;
            end else begin
               n_run = 1'b0;
            end
         end else if (m_run) begin
            if (m_tval > 0) begin
               n_tval = m_tval - 1;
               expire = (m_tval == 1);
            end else if (m_tcfg[1]) begin
               n_tval = m_tcfg & 32'hFFFF_FFFC;
            end else begin
               n_run = 1'b0;
            end
         end
         if (a == 14'h44 && WB_csr_we[0] && WB_csr_wdata[0]) n_ti = 1'b0;
         if (expire) n_ti = 1'b1;
      end
   endtask

   task automatic model_commit();
      m_crmd = n_crmd; m_prmd = n_prmd; m_ecfg = n_ecfg; m_era = n_era; m_badv = n_badv;
      m_eentry = n_eentry; m_tid = n_tid; m_tcfg = n_tcfg; m_tval = n_tval; m_run = n_run;
      m_sw = n_sw; m_hw = n_hw; m_ti = n_ti; m_ec = n_ec;
      for (int i = 0; i < 4; i++) m_save[i] = n_save[i];
   endtask

   task automatic tick();
      model_next();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic idle();
      WB_csr_waddr = 14'h2; WB_csr_we = 0; WB_csr_wdata = 0; WB_ertn = 0;
      WB_ecode_in = 0; WB_ecode_we = 0; WB_badv_in = 0; WB_badv_we = 0;
      WB_era_in = 0; WB_era_we = 0; WB_era_en = 0; WB_eentry_en = 0;
      WB_store_state = 0; WB_restore_state = 0;
   endtask

   task automatic wr(input logic [13:0] a, input logic [31:0] we, input logic [31:0] d);
      WB_csr_waddr = a; WB_csr_we = we; WB_csr_wdata = d;
   endtask

   task automatic lit(input string name, input logic [13:0] a, input logic [31:0] exp);
      csr_raddr = a;
      #1;
      check(name, csr_rdata, exp);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         logic [31:0] es, exp_pc;
         logic        exp_int;
         es = m_estat();
         exp_int = m_crmd[2] & (|(es[12:0] & m_ecfg[12:0]));
         exp_pc = WB_eentry_en ? m_eentry : (WB_era_en ? m_era : 32'd0);
         check("rdata", csr_rdata, m_read(csr_raddr));
         check("redirect_pc", csr_redirect_pc, exp_pc);
         check("int_pending", {31'd0, int_pending}, {31'd0, exp_int});
         check("crmd_plv", {30'd0, crmd_plv}, {30'd0, m_crmd[1:0]});
         check("crmd_ie", {31'd0, crmd_ie}, {31'd0, m_crmd[2]});
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      idle();
      ext_int = 0;
      csr_raddr = 0;
      rst = 1;
      tick();
      chk_en = 1'b1;
      tick();
      rst = 0;

      for (int i = 0; i < 18; i++) begin
         logic [31:0] e;
         e = (addrs[i] == 14'h0) ? 32'h8 : ((addrs[i] == 14'h40) ? TIDR : 32'd0);
         lit("reset_read", addrs[i], e);
         tick();
      end
      check("reset_int_pending", {31'd0, int_pending}, 32'd0);

      wr(14'h0, 32'h3, 32'hFFFF_FFFF); tick(); idle();
      lit("crmd_masked_wr", 14'h0, 32'hB);
      wr(14'h0, 32'h0, 32'hFFFF_FFFF); tick(); idle();
      lit("crmd_we0", 14'h0, 32'hB);

      wr(14'h0, 32'h7, 32'h7); tick();
      wr(14'hC, 32'hFFFF_FFFF, 32'h1C00_8000); tick(); idle();
      WB_store_state = 1; WB_ecode_we = 1; WB_ecode_in = 7'h48;
      WB_era_we = 1; WB_era_in = 32'h1C00_0100; WB_eentry_en = 1;
      #1;
      check("exc_redirect", csr_redirect_pc, 32'h1C00_8000);
      tick(); idle();
      lit("exc_prmd", 14'h1, 32'h7);
      check("exc_plv", {30'd0, crmd_plv}, 32'd0);
      check("exc_ie", {31'd0, crmd_ie}, 32'd0);
      lit("exc_estat", 14'h5, 32'h0048_0000);
      lit("exc_era", 14'h6, 32'h1C00_0100);

      WB_ertn = 1; WB_restore_state = 1; WB_era_en = 1;
      #1;
      check("ertn_redirect", csr_redirect_pc, 32'h1C00_0100);
      tick(); idle();
      check("ertn_plv", {30'd0, crmd_plv}, 32'd3);
      check("ertn_ie", {31'd0, crmd_ie}, 32'd1);

      wr(14'h4, 32'hFFFF_FFFF, 32'h800); tick();
      wr(14'h41, 32'hFFFF_FFFF, 32'h13); tick(); idle();
      lit("tval_load", 14'h42, 32'd16);
      csr_raddr = 14'h5;
      cnt = 0;
      do begin
         tick();
         cnt++;
      end while (!csr_rdata[11] && cnt < 100);
      check("timer_expire_cycles", cnt, 32'd16);
      check("timer_int_pending", {31'd0, int_pending}, 32'd1);
      tick();
      lit("tval_reload", 14'h42, 32'd16);
      wr(14'h44, 32'h1, 32'h1); tick(); idle();
      lit("ticlr_clear_first", 14'h5, m_estat() & 32'hFFFF_F7FF);

      cnt = 0;
      while (!(m_run && m_tval == 1) && cnt < 100) begin
         tick();
         cnt++;
      end
      check("wait_tval1_bound", {31'd0, cnt < 100}, 32'd1);
      wr(14'h44, 32'h1, 32'h1); tick(); idle();
      csr_raddr = 14'h5; #1;
      check("ticlr_vs_expire", {31'd0, csr_rdata[11]}, 32'd1);
      tick(); tick();
      wr(14'h44, 32'h1, 32'h1); tick(); idle();
      csr_raddr = 14'h5; #1;
      check("ticlr_later", {31'd0, csr_rdata[11]}, 32'd0);
      check("ticlr_int_pending", {31'd0, int_pending}, 32'd0);

      for (int c = 0; c < 1500; c++) begin
         int r;
         logic [13:0] a;
         idle();
         rst = ($urandom_range(0, 299) == 0);
         a = addrs[$urandom_range(0, 17)];
         r = $urandom_range(0, 3);
         WB_csr_waddr = a;
         WB_csr_we = (r == 0) ? 32'd0 : ((r == 1) ? 32'hFFFF_FFFF : $urandom);
         WB_csr_wdata = $urandom;
         if (a == 14'h41) begin
            WB_csr_wdata = $urandom_range(0, 120);
            if (WB_csr_we != 0) WB_csr_we = 32'hFFFF_FFFF;
         end
         WB_store_state   = ($urandom_range(0, 7) == 0);
         WB_restore_state = ($urandom_range(0, 7) == 0);
         WB_ertn          = WB_restore_state;
         WB_era_en        = ($urandom_range(0, 7) == 0);
         WB_eentry_en     = ($urandom_range(0, 7) == 0);
         WB_ecode_we      = ($urandom_range(0, 3) == 0);
         WB_ecode_in      = 7'($urandom);
         WB_era_we        = ($urandom_range(0, 3) == 0);
         WB_era_in        = $urandom;
         WB_badv_we       = ($urandom_range(0, 3) == 0);
         WB_badv_in       = $urandom;
         ext_int          = 8'($urandom);
         csr_raddr        = addrs[$urandom_range(0, 17)];
         tick();
      end
      rst = 0;
      idle();
      tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
